// File: rtl/sync_downcnt.sv
// sync_downcnt: loadable synchronous down-counter with one-shot or periodic auto-reload and a one-cycle terminal-count pulse
module sync_downcnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         en,
  input  logic         mode,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [W-1:0] q_q, q_d, reload_q, reload_d;
  logic tc_q, tc_d;
  logic term;
  always_comb begin
    term     = state_q == RUN && en && q_q == W'(1);
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    state_d  = state_q;
    if (load) begin
      q_d      = din;
      reload_d = din;
      state_d  = din != '0 ? RUN : IDLE;
    end else if (term) begin
      tc_d    = 1'b1;
      q_d     = mode ? reload_q : '0;
      state_d = mode ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      q_d = q_q - W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      state_q  <= IDLE;
    end else begin
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      state_q  <= state_d;
    end
  end
  assign q    = q_q;
  assign tc   = tc_q;
  assign busy = state_q == RUN;
endmodule
